// File: rtl/addsub_pkg.sv
// Shared definitions for the accumulator unit and its ripple-carry datapath.
//   DATA_W                       operand / accumulator width
//   OP_LOAD/OP_ADD/OP_SUB/OP_CLEAR  command encodings on the Op port
//   state_t                      output-register occupancy state
//   signed_ovf()                 two's complement overflow from sign bits
package addsub_pkg;

    localparam int DATA_W = 4;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Overflow occurs when both adder inputs share a sign and the sum's sign differs.
    // bx_msb is the sign of the operand as actually presented to the adder
    // (already inverted for subtraction).
    function automatic logic signed_ovf(input logic a_msb, input logic bx_msb,
                                        input logic s_msb);
        signed_ovf = (a_msb == bx_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/four_bit_RCS.sv
// 4-bit ripple-carry adder/subtractor, purely combinational.
//   A, B  operands
//   Sub   1 = A - B (B inverted, carry-in forced to 1), 0 = A + B
//   S     4-bit result modulo 16
//   Cout  carry out of bit 3; during subtraction 1 means no borrow
module four_bit_RCS (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Sub,
    output logic [3:0] S,
    output logic       Cout
);

    logic [3:0] bx_s;
    logic       c1_s;
    logic       c2_s;
    logic       c3_s;

    assign bx_s = B ^ {4{Sub}};

    // Each stage is a full adder; the chain is spelled out bit by bit.
    assign S[0] = A[0] ^ bx_s[0] ^ Sub;
    assign c1_s = (A[0] & bx_s[0]) | (A[0] & Sub)  | (bx_s[0] & Sub);
    assign S[1] = A[1] ^ bx_s[1] ^ c1_s;
    assign c2_s = (A[1] & bx_s[1]) | (A[1] & c1_s) | (bx_s[1] & c1_s);
    assign S[2] = A[2] ^ bx_s[2] ^ c2_s;
    assign c3_s = (A[2] & bx_s[2]) | (A[2] & c2_s) | (bx_s[2] & c2_s);
    assign S[3] = A[3] ^ bx_s[3] ^ c3_s;
    assign Cout = (A[3] & bx_s[3]) | (A[3] & c3_s) | (bx_s[3] & c3_s);

endmodule

// File: rtl/addsub_acc_unit.sv
// Registered accumulator around a single four_bit_RCS, with valid/ready on
// both the command and the result side (single-entry, pass-through ready).
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     command handshake; Op and B sampled on accept
//   Op, B                 command (LOAD/ADD/SUB/CLEAR) and operand
//   out_valid/out_ready   result handshake
//   Acc, Cout, V, Z, N    accumulator and flags of the last accepted command
//   V_sticky              OR of overflow since the last LOAD/CLEAR
//   op_count              saturating count of commands since reset/LOAD/CLEAR
module addsub_acc_unit
    import addsub_pkg::*;
#(
    parameter logic [DATA_W-1:0] ACC_INIT = 4'b0000,
    parameter int                CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        Op,
    input  logic [DATA_W-1:0] B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] Acc,
    output logic              Cout,
    output logic              V,
    output logic              Z,
    output logic              N,
    output logic              V_sticky,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state_r;
    logic [DATA_W-1:0]   acc_r;
    logic                cout_r;
    logic                v_r;
    logic                z_r;
    logic                n_r;
    logic                v_sticky_r;
    logic [CNT_W-1:0]    op_count_r;

    logic                accept_s;
    logic                sub_s;
    logic [DATA_W-1:0]   sum_s;
    logic                rcs_cout_s;
    logic [DATA_W-1:0]   bx_s;
    logic                v_new_s;
    logic [CNT_W-1:0]    cnt_inc_s;

    logic [DATA_W-1:0]   acc_nxt_s;
    logic                cout_nxt_s;
    logic                v_nxt_s;
    logic                v_sticky_nxt_s;
    logic [CNT_W-1:0]    op_count_nxt_s;

    // Ready may pass through: a full register can be drained and refilled in one cycle.
    assign in_ready = (state_r == ST_EMPTY) || out_ready;
    assign accept_s = in_valid && in_ready;

    assign sub_s = (Op == OP_SUB);

    four_bit_RCS u_rcs (
        .A    (acc_r),
        .B    (B),
        .Sub  (sub_s),
        .S    (sum_s),
        .Cout (rcs_cout_s)
    );

    // Operand sign as seen by the adder, then overflow and saturating count increment.
    always_comb begin
        bx_s    = sub_s ? ~B : B;
        v_new_s = signed_ovf(acc_r[DATA_W-1], bx_s[DATA_W-1], sum_s[DATA_W-1]);
        if (op_count_r == CNT_MAX) begin
            cnt_inc_s = CNT_MAX;
        end else begin
            cnt_inc_s = op_count_r + CNT_ONE;
        end
    end

    // Next-state value of the accumulator and flags for the presented command.
    always_comb begin
        acc_nxt_s      = acc_r;
        cout_nxt_s     = cout_r;
        v_nxt_s        = v_r;
        v_sticky_nxt_s = v_sticky_r;
        op_count_nxt_s = op_count_r;
        case (Op)
            OP_LOAD: begin
                acc_nxt_s      = B;
                cout_nxt_s     = 1'b0;
                v_nxt_s        = 1'b0;
                v_sticky_nxt_s = 1'b0;
                op_count_nxt_s = CNT_ONE;
            end
            OP_ADD, OP_SUB: begin
                acc_nxt_s      = sum_s;
                cout_nxt_s     = rcs_cout_s;
                v_nxt_s        = v_new_s;
                v_sticky_nxt_s = v_sticky_r | v_new_s;
                op_count_nxt_s = cnt_inc_s;
            end
            OP_CLEAR: begin
                acc_nxt_s      = {DATA_W{1'b0}};
                cout_nxt_s     = 1'b0;
                v_nxt_s        = 1'b0;
                v_sticky_nxt_s = 1'b0;
                op_count_nxt_s = {CNT_W{1'b0}};
            end
            default: begin
                acc_nxt_s      = acc_r;
                cout_nxt_s     = cout_r;
                v_nxt_s        = v_r;
                v_sticky_nxt_s = v_sticky_r;
                op_count_nxt_s = op_count_r;
            end
        endcase
    end

    // Occupancy FSM plus the result registers it gates; Z/N are registered
    // from the same next accumulator value so they always match Acc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_EMPTY;
            acc_r      <= ACC_INIT;
            cout_r     <= 1'b0;
            v_r        <= 1'b0;
            z_r        <= (ACC_INIT == {DATA_W{1'b0}});
            n_r        <= ACC_INIT[DATA_W-1];
            v_sticky_r <= 1'b0;
            op_count_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_r <= ST_FULL;
                    end else begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (accept_s) begin
                        state_r <= ST_FULL;
                    end else if (out_ready) begin
                        state_r <= ST_EMPTY;
                    end else begin
                        state_r <= ST_FULL;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase

            if (accept_s) begin
                acc_r      <= acc_nxt_s;
                cout_r     <= cout_nxt_s;
                v_r        <= v_nxt_s;
                z_r        <= (acc_nxt_s == {DATA_W{1'b0}});
                n_r        <= acc_nxt_s[DATA_W-1];
                v_sticky_r <= v_sticky_nxt_s;
                op_count_r <= op_count_nxt_s;
            end else begin
                acc_r      <= acc_r;
                cout_r     <= cout_r;
                v_r        <= v_r;
                z_r        <= z_r;
                n_r        <= n_r;
                v_sticky_r <= v_sticky_r;
                op_count_r <= op_count_r;
            end
        end
    end

    assign out_valid = (state_r == ST_FULL);
    assign Acc       = acc_r;
    assign Cout      = cout_r;
    assign V         = v_r;
    assign Z         = z_r;
    assign N         = n_r;
    assign V_sticky  = v_sticky_r;
    assign op_count  = op_count_r;

endmodule

// File: tb/tb_addsub_acc_unit.sv
// Directed bench for addsub_acc_unit with an arithmetic reference model and
// an expected-result queue filled on accept and drained after each edge.
module tb_addsub_acc_unit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] Op;
    logic [3:0] B;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] Acc;
    logic       Cout;
    logic       V;
    logic       Z;
    logic       N;
    logic       V_sticky;
    logic [7:0] op_count;

    typedef struct packed {
        logic [3:0] acc;
        logic       cout;
        logic       v;
        logic       vs;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t m;
    logic m_full;
    int   checks;
    int   errors;

    addsub_acc_unit #(.ACC_INIT(4'b0000), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Op        (Op),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Acc       (Acc),
        .Cout      (Cout),
        .V         (V),
        .Z         (Z),
        .N         (N),
        .V_sticky  (V_sticky),
        .op_count  (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference arithmetic uses integer sums and signed range tests.
    function automatic exp_t model(input exp_t cur, input logic [1:0] op, input logic [3:0] b);
        exp_t r;
        logic [4:0] w;
        int sa;
        int sb;
        int sr;
        r  = cur;
        sa = int'($signed(cur.acc));
        sb = int'($signed(b));
        case (op)
            2'b00: begin
                r.acc = b; r.cout = 1'b0; r.v = 1'b0; r.vs = 1'b0; r.cnt = 8'd1;
            end
            2'b01, 2'b10: begin
                if (op == 2'b01) begin
                    w  = {1'b0, cur.acc} + {1'b0, b};
                    sr = sa + sb;
                end else begin
                    w  = {1'b0, cur.acc} + {1'b0, ~b} + 5'd1;
                    sr = sa - sb;
                end
                r.acc  = w[3:0];
                r.cout = w[4];
                r.v    = (sr > 7) || (sr < -8);
                r.vs   = cur.vs | r.v;
                r.cnt  = (cur.cnt == 8'hFF) ? 8'hFF : cur.cnt + 8'd1;
            end
            default: begin
                r.acc = 4'd0; r.cout = 1'b0; r.v = 1'b0; r.vs = 1'b0; r.cnt = 8'd0;
            end
        endcase
        return r;
    endfunction

    task automatic check_outs(input string tag, input exp_t e);
        chk({tag, ".acc"},  32'(Acc),      32'(e.acc));
        chk({tag, ".cout"}, 32'(Cout),     32'(e.cout));
        chk({tag, ".v"},    32'(V),        32'(e.v));
        chk({tag, ".vs"},   32'(V_sticky), 32'(e.vs));
        chk({tag, ".cnt"},  32'(op_count), 32'(e.cnt));
        chk({tag, ".z"},    32'(Z),        32'(e.acc == 4'd0));
        chk({tag, ".n"},    32'(N),        32'(e.acc[3]));
    endtask

    // One clock of stimulus: drive at negedge, predict accept, compare after posedge.
    task automatic step(input string tag, input logic [1:0] op, input logic [3:0] b,
                        input logic iv, input logic ordy);
        logic exp_ir;
        logic acc_now;
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        Op        = op;
        B         = b;
        out_ready = ordy;
        #1;
        exp_ir  = !m_full || ordy;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ir));
        acc_now = iv && exp_ir;
        if (acc_now) begin
            m = model(m, op, b);
            sb_q.push_back(m);
        end
        @(posedge clk);
        #1;
        if (acc_now) m_full = 1'b1;
        else if (ordy) m_full = 1'b0;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_full));
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_outs(tag, e);
        end else begin
            check_outs({tag, ".hold"}, m);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        m         = '0;
        m_full    = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        Op        = 2'b00;
        B         = 4'b0000;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", m);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // LOAD 0111 then ADD 0001: positive overflow into 1000.
        step("load7", 2'b00, 4'b0111, 1'b1, 1'b1);
        step("add1",  2'b01, 4'b0001, 1'b1, 1'b1);
        chk("add1.acc_const", 32'(Acc), 32'h8);
        chk("add1.v_const",   32'(V),   32'd1);
        chk("add1.cnt_const", 32'(op_count), 32'd2);

        // LOAD 1000, SUB 0001: negative overflow, no borrow.
        step("load8", 2'b00, 4'b1000, 1'b1, 1'b1);
        step("sub1",  2'b10, 4'b0001, 1'b1, 1'b1);
        chk("sub1.acc_const",  32'(Acc),  32'h7);
        chk("sub1.cout_const", 32'(Cout), 32'd1);

        // LOAD 0001, SUB 0010: borrow, result -1.
        step("load1", 2'b00, 4'b0001, 1'b1, 1'b1);
        step("sub2",  2'b10, 4'b0010, 1'b1, 1'b1);
        chk("sub2.acc_const",  32'(Acc),  32'hF);
        chk("sub2.cout_const", 32'(Cout), 32'd0);
        chk("sub2.vs_const",   32'(V_sticky), 32'd0);

        // Backpressure: command held three cycles, then same-cycle drain and accept.
        for (int i = 0; i < 3; i++) begin
            step("stall", 2'b01, 4'b0001, 1'b1, 1'b0);
        end
        chk("stall.acc_const", 32'(Acc), 32'hF);
        step("release", 2'b01, 4'b0001, 1'b1, 1'b1);
        chk("release.acc_const", 32'(Acc), 32'h0);
        chk("release.valid_const", 32'(out_valid), 32'd1);
        step("drain", 2'b00, 4'b0000, 1'b0, 1'b1);

        // Overflow sequence then CLEAR.
        step("ov_load", 2'b00, 4'b0111, 1'b1, 1'b1);
        step("ov_add",  2'b01, 4'b0111, 1'b1, 1'b1);
        step("ov_add2", 2'b01, 4'b0001, 1'b1, 1'b1);
        chk("ov.vs_const", 32'(V_sticky), 32'd1);
        step("clear",   2'b11, 4'b1010, 1'b1, 1'b1);
        chk("clear.acc_const", 32'(Acc), 32'h0);
        chk("clear.z_const",   32'(Z),   32'd1);
        chk("clear.cnt_const", 32'(op_count), 32'd0);

        // 256 increments: wrap at the 16th, counter saturates.
        for (int i = 0; i < 256; i++) begin
            step("inc", 2'b01, 4'b0001, 1'b1, 1'b1);
            if (i == 15) chk("inc16.acc_const", 32'(Acc), 32'h0);
        end
        chk("sat.cnt_const", 32'(op_count), 32'd255);

        // Mid-cycle asynchronous reset while a result is held.
        step("pre_rst", 2'b00, 4'b0101, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        sb_q.delete();
        m      = '0;
        m_full = 1'b0;
        check_outs("async_rst", m);
        chk("async_rst.out_valid", 32'(out_valid), 32'd0);
        #1;
        rst = 1'b0;
        step("post_rst", 2'b00, 4'b0000, 1'b0, 1'b1);
        step("post_add", 2'b01, 4'b0011, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
